// File: rtl/rate_meter.sv
// rate_meter: measures the tick-to-tick period of tick_in in clk_in cycles.
// It classifies each period against three nominal rates and locks onto a
// rate code once enough consecutive periods agree. Loss of lock, by mismatch
// or by timeout, pulses err.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for the first tick event; no period reference yet
// MEASURE | periods being measured, match counter building toward lock
// LOCKED  | sel_out confirmed; each period must keep matching sel_out
module rate_meter #(
  parameter int unsigned PERIOD_1   = 5000001,
  parameter int unsigned PERIOD_2   = 12500001,
  parameter int unsigned PERIOD_3   = 25000001,
  parameter int unsigned TOL        = 2,
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned TIMEOUT    = 33554432
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        tick_in,
  output logic [31:0] period,
  output logic        period_valid,
  output logic [1:0]  sel_out,
  output logic        locked,
  output logic        err
);

  localparam logic [31:0] P1_W      = 32'(PERIOD_1);
  localparam logic [31:0] P2_W      = 32'(PERIOD_2);
  localparam logic [31:0] P3_W      = 32'(PERIOD_3);
  localparam logic [31:0] TOL_W     = 32'(TOL);
  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);
  localparam logic [3:0]  LOCK_W    = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q;
  logic        tick_q;
  logic        tick_ev;
  logic [3:0]  mc_q, mc_d, mc_seed;
  logic [1:0]  prev_q, prev_d;
  logic [1:0]  code;
  logic        timeout;
  logic [31:0] period_d;
  logic        pv_d;
  logic [1:0]  sel_d;
  logic        locked_d;
  logic        err_d;

  // Absolute difference computed without wrap so huge periods never alias
  // back into a tolerance window.
  function automatic logic near(input logic [31:0] p, input logic [31:0] nom);
    logic [31:0] d;
    d = (p >= nom) ? (p - nom) : (nom - p);
    return (d <= TOL_W);
  endfunction

  // First matching rate wins, in order 1, 2, 3.
  function automatic logic [1:0] classify(input logic [31:0] p);
    logic [1:0] c;
    c = 2'd0;
    if (near(p, P1_W))      c = 2'd1;
    else if (near(p, P2_W)) c = 2'd2;
    else if (near(p, P3_W)) c = 2'd3;
    return c;
  endfunction

  assign tick_ev = tick_in & ~tick_q;
  assign code    = classify(cnt_q);
  // A tick on the timeout edge wins, so timeout is only seen without one.
  assign timeout = (cnt_q == TIMEOUT_W) & ~tick_ev;

  // Match counter value the current period would produce.
  always_comb begin
    mc_seed = 4'd0;
    if (code != 2'd0) begin
      if (code == prev_q) mc_seed = mc_q + 4'd1;
      else                mc_seed = 4'd1;
    end
  end

  // Tick edge history and the saturating period counter.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
      cnt_q  <= 32'd0;
    end else begin
      tick_q <= tick_in;
      if (tick_ev)                cnt_q <= 32'd1;
      else if (cnt_q != TIMEOUT_W) cnt_q <= cnt_q + 32'd1;
    end
  end

  // FSM state, match tracking and registered outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mc_q         <= 4'd0;
      prev_q       <= 2'd0;
      period       <= 32'd0;
      period_valid <= 1'b0;
      sel_out      <= 2'd0;
      locked       <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      mc_q         <= mc_d;
      prev_q       <= prev_d;
      period       <= period_d;
      period_valid <= pv_d;
      sel_out      <= sel_d;
      locked       <= locked_d;
      err          <= err_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d  = state_q;
    mc_d     = mc_q;
    prev_d   = prev_q;
    period_d = period;
    pv_d     = 1'b0;
    sel_d    = sel_out;
    locked_d = locked;
    err_d    = 1'b0;

    if (tick_ev) begin
      unique case (state_q)
        IDLE: begin
          // First tick only opens the measurement window.
          state_d = MEASURE;
          mc_d    = 4'd0;
          prev_d  = 2'd0;
        end
        MEASURE: begin
          period_d = cnt_q;
          pv_d     = 1'b1;
          prev_d   = code;
          mc_d     = mc_seed;
          if ((code != 2'd0) && (mc_seed == LOCK_W)) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
            sel_d    = code;
          end
        end
        LOCKED: begin
          period_d = cnt_q;
          pv_d     = 1'b1;
          prev_d   = code;
          if (code != sel_out) begin
            state_d  = MEASURE;
            err_d    = 1'b1;
            locked_d = 1'b0;
            sel_d    = 2'd0;
            mc_d     = mc_seed;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else if (timeout) begin
      state_d  = IDLE;
      mc_d     = 4'd0;
      prev_d   = 2'd0;
      locked_d = 1'b0;
      sel_d    = 2'd0;
      err_d    = (state_q == LOCKED);
    end
  end

endmodule

// File: tb/tb_rate_meter.sv
// Scoreboard bench for rate_meter: stimulus pushes hand-computed expected
// responses, a monitor pops one whenever period_valid or err is seen.
module tb_rate_meter;

  logic        clk_in;
  logic        rst_n;
  logic        tick_in;
  logic [31:0] period;
  logic        period_valid;
  logic [1:0]  sel_out;
  logic        locked;
  logic        err;

  int tests;
  int fails;

  typedef struct {
    logic [31:0] p;
    logic        pv;
    logic [1:0]  s;
    logic        l;
    logic        e;
  } exp_t;

  exp_t exp_q[$];

  rate_meter #(
    .PERIOD_1(6), .PERIOD_2(15), .PERIOD_3(30),
    .TOL(1), .LOCK_COUNT(3), .TIMEOUT(64)
  ) dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .tick_in(tick_in),
    .period(period),
    .period_valid(period_valid),
    .sel_out(sel_out),
    .locked(locked),
    .err(err)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic push(input logic [31:0] p, input logic pv, input logic [1:0] s,
                      input logic l, input logic e);
    exp_t x;
    x.p = p; x.pv = pv; x.s = s; x.l = l; x.e = e;
    exp_q.push_back(x);
  endtask

  // One tick (held high for len cycles), then low until gap cycles elapse.
  // has_exp: this tick's measurement is expected to appear on the outputs.
  task automatic tk(input int gap, input int len, input bit has_exp,
                    input logic [31:0] p, input logic [1:0] s,
                    input logic l, input logic e);
    if (has_exp) push(p, 1'b1, s, l, e);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk_in);
      tick_in = (i < len);
    end
  endtask

  task automatic check_zero(input string name);
    tests++;
    if (period !== 32'd0 || period_valid !== 1'b0 || sel_out !== 2'd0 ||
        locked !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL %s: got period=%0d pv=%b sel=%0d locked=%b err=%b, want all 0",
               name, period, period_valid, sel_out, locked, err);
    end
  endtask

  // Monitor: every output event must match the next queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk_in);
      if (rst_n && (period_valid || err)) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: got period=%0d pv=%b sel=%0d locked=%b err=%b, want no event",
                   period, period_valid, sel_out, locked, err);
        end else begin
          x = exp_q.pop_front();
          if (period !== x.p || period_valid !== x.pv || sel_out !== x.s ||
              locked !== x.l || err !== x.e) begin
            fails++;
            $display("FAIL event@%0t: got period=%0d pv=%b sel=%0d locked=%b err=%b, want period=%0d pv=%b sel=%0d locked=%b err=%b",
                     $time, period, period_valid, sel_out, locked, err,
                     x.p, x.pv, x.s, x.l, x.e);
          end
        end
      end
    end
  end

  initial begin
    tests   = 0;
    fails   = 0;
    rst_n   = 1'b0;
    tick_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check_zero("reset_state");
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);

    // Code 1 lock on the 4th tick event
    tk(6, 1, 0, 0, 0, 0, 0);
    tk(6, 1, 1, 6, 0, 0, 0);
    tk(6, 1, 1, 6, 0, 0, 0);
    tk(6, 1, 1, 6, 1, 1, 0);
    tk(30, 1, 1, 6, 1, 1, 0);
    // Mismatch to code 3, relock at 3
    tk(30, 1, 1, 30, 0, 0, 1);
    tk(30, 1, 1, 30, 0, 0, 0);
    tk(20, 1, 1, 30, 3, 1, 0);
    // Period 20 breaks lock, three 30s relock
    tk(30, 1, 1, 20, 0, 0, 1);
    tk(30, 1, 1, 30, 0, 0, 0);
    tk(30, 1, 1, 30, 0, 0, 0);
    tk(14, 1, 1, 30, 3, 1, 0);
    // 14, 16, 15 all code 2; 17 is code 0
    tk(16, 1, 1, 14, 0, 0, 1);
    tk(15, 1, 1, 16, 0, 0, 0);
    tk(17, 1, 1, 15, 2, 1, 0);
    tk(15, 1, 1, 17, 0, 0, 1);
    // Relock code 2, then timeout while locked
    tk(15, 1, 1, 15, 0, 0, 0);
    tk(15, 1, 1, 15, 0, 0, 0);
    push(32'd15, 1'b1, 2'd2, 1'b1, 1'b0);
    push(32'd15, 1'b0, 2'd0, 1'b0, 1'b1);
    tk(80, 1, 0, 0, 0, 0, 0);
    // After timeout the first tick yields nothing; held-high ticks
    tk(15, 5, 0, 0, 0, 0, 0);
    tk(15, 5, 1, 15, 0, 0, 0);
    tk(15, 5, 1, 15, 0, 0, 0);
    tk(20, 5, 1, 15, 2, 1, 0);
    // Break lock, then a tick exactly at counter==TIMEOUT is measured
    tk(64, 1, 1, 20, 0, 0, 1);
    tk(80, 1, 1, 64, 0, 0, 0);
    // Timeout from MEASURE: no err, next tick starts fresh
    tk(6, 1, 0, 0, 0, 0, 0);
    tk(6, 1, 1, 6, 0, 0, 0);
    tk(6, 1, 1, 6, 0, 0, 0);
    tk(3, 1, 1, 6, 1, 1, 0);
    // One-edge reset while locked
    rst_n = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    check_zero("reset_in_locked");
    tk(6, 1, 0, 0, 0, 0, 0);
    tk(6, 1, 1, 6, 0, 0, 0);
    tk(6, 1, 1, 6, 0, 0, 0);
    tk(6, 1, 1, 6, 1, 1, 0);
    repeat (20) @(negedge clk_in);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d expected events still pending, want 0", exp_q.size());
    end
    tests++;
    if (locked !== 1'b1 || sel_out !== 2'd1) begin
      fails++;
      $display("FAIL final_lock: got locked=%b sel=%0d, want locked=1 sel=1", locked, sel_out);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rate_meter.md
RATE_METER -- requirements
Module: rate_meter

Parameters
REQ-001 The block SHALL expose parameter PERIOD_1, default 5000001, meaning the nominal tick period in clk_in cycles for rate code 1.
REQ-002 The block SHALL expose parameter PERIOD_2, default 12500001, meaning the nominal tick period for rate code 2.
REQ-003 The block SHALL expose parameter PERIOD_3, default 25000001, meaning the nominal tick period for rate code 3.
REQ-004 The block SHALL expose parameter TOL, default 2, meaning the allowed ± deviation in cycles when matching a period.
REQ-005 The block SHALL expose parameter LOCK_COUNT, default 3, meaning the number of consecutive same-code periods required to lock; legal range 1..15.
REQ-006 The block SHALL expose parameter TIMEOUT, default 33554432, meaning the cycle count without a tick event that forces loss of lock; TIMEOUT > PERIOD_3+TOL.

Interface
REQ-007 clk_in  input  1  single clock; all logic on its rising edge.
REQ-008 rst_n  input  1  reset, synchronous, active-low.
REQ-009 tick_in  input  1  pulse stream from a rate generator, synchronous to clk_in.
REQ-010 period  output  32  last measured tick-to-tick period in cycles.
REQ-011 period_valid  output  1  one-cycle strobe, high when period updates.
REQ-012 sel_out  output  2  decoded rate code (0 = none/unknown, 1..3 = PERIOD_1..3).
REQ-013 locked  output  1  high while sel_out is confirmed.
REQ-014 err  output  1  one-cycle strobe on loss of lock (mismatch or timeout).

Function
REQ-015 Tick event SHALL be tick_in high on this edge while it was low on the previous edge; a held-high tick_in counts as one event.
REQ-016 The cycle counter SHALL be set to 1 on each tick event and incremented otherwise, saturating at TIMEOUT.
REQ-017 Measured period SHALL equal the edge distance between consecutive tick events (events at edges 0 and 6 -> 6).
REQ-018 On a tick event in MEASURE or LOCKED, period and period_valid SHALL be registered on that same edge (visible the following cycle); period_valid is high for exactly one cycle.
REQ-019 Classification SHALL give code k if |period - PERIOD_k| <= TOL, checking k = 1, 2, 3 in order, else code 0; comparisons are unsigned 32-bit with no wrap.
REQ-020 The FSM SHALL have states IDLE, MEASURE, LOCKED.
REQ-021 IDLE: the first tick event SHALL move to MEASURE without producing period_valid.
REQ-022 MEASURE: a match counter SHALL increment when the code is nonzero and equals the previous code, SHALL load 1 when the code is nonzero and differs, and SHALL clear when the code is 0.
REQ-023 MEASURE: when the match counter reaches LOCK_COUNT, the FSM SHALL enter LOCKED, set locked=1 and set sel_out to the code on the same edge.
REQ-024 LOCKED: a period matching sel_out SHALL keep state; a non-matching period SHALL pulse err, clear locked, set sel_out=0, go to MEASURE, and seed the match counter per REQ-022.
REQ-025 In any state, the counter reaching TIMEOUT SHALL return the FSM to IDLE, clear locked, sel_out and the match counter, and pulse err only if the FSM was LOCKED.
REQ-026 A tick event on the same edge as the timeout SHALL take priority: it is processed as a normal tick and no timeout occurs.
REQ-027 With LOCK_COUNT=1, the first classified nonzero period SHALL lock immediately.

Reset
REQ-028 While rst_n=0 at a clk_in edge: state=IDLE, counter=0, match counter=0, period=0, period_valid=0, sel_out=0, locked=0, err=0, and the tick edge-detect history=0.
REQ-029 Reset asserted mid-measurement SHALL discard all partial counts; the first tick event after release is treated per REQ-021.

Verification (PERIOD_1=6, PERIOD_2=15, PERIOD_3=30, TOL=1, LOCK_COUNT=3, TIMEOUT=64)
REQ-030 1-cycle ticks every 6 cycles -> period=6 with period_valid on each tick after the first; locked=1 and sel_out=1 on the 4th tick event.
REQ-031 Locked at code 3 (period 30), one period of 20 -> err pulses once, locked=0, sel_out=0, match counter 0; three further 30-cycle periods relock to sel_out=3.
REQ-032 Periods 14, 16, 15 -> all classify as code 2 -> locked after the third; period 17 -> code 0, loss of lock with err.
REQ-033 Locked, then tick_in held low -> on the 64th cycle after the last tick: IDLE, locked=0, err pulse; the next tick produces no period_valid.
REQ-034 tick_in held high for 5 cycles in each 15-cycle period -> one event per period, period=15; a tick event coincident with counter=TIMEOUT is processed with no err.
REQ-035 rst_n=0 for one edge during LOCKED -> all outputs 0 on the next cycle; relock requires 1+LOCK_COUNT fresh tick events.
